// File: rtl/pio_led_pattern_driver.sv
// -----------------------------------------------------------------------------
// pio_led_pattern_driver
//
// Turns the 2-bit PIO out_port value into one of four LED patterns for two
// board LEDs:
//   00 OFF      both LEDs dark
//   01 STEADY   both LEDs lit
//   10 BLINK    LEDs alternate (01 / 10), each phase lasting BLINK_HALF cycles
//   11 BREATHE  both LEDs PWM-dimmed, duty ramping 0..MAX..0 one step every
//               STEP_DIV cycles
//
// The mode input is registered once (mode_q). The LED outputs are then decoded
// from mode_q and registered, so a new mode shows on led two clocks after it
// is presented. Any change of mode restarts every pattern counter from zero.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   mode[1:0]      pattern select from the PIO out_port (already in clk domain)
//   led[1:0]       LED drive, 1 = lit
//   pattern_active high whenever the registered mode is non-zero
// -----------------------------------------------------------------------------
module pio_led_pattern_driver #(
  parameter int unsigned BLINK_HALF = 25000000,  // >= 2
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 97656      // >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic [1:0] led,
  output logic       pattern_active
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  mode_e               mode_q,      mode_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q,     phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
  logic [SW-1:0]       step_cnt_q,  step_cnt_d;
  logic [PWM_BITS-1:0] duty_q,      duty_d;
  dir_e                dir_q,       dir_d;
  logic [1:0]          led_q,       led_d;
  logic                active_q,    active_d;

  logic mode_change;
  assign mode_change = (mode != mode_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; this is what keeps the block free of inferred latches.
    // The defaults are also the "held at zero" values for unused counters.
    mode_d      = mode_e'(mode);
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    pwm_cnt_d   = '0;
    step_cnt_d  = '0;
    duty_d      = '0;
    dir_d       = DIR_UP;

    // Output decode always looks at the registered mode and current counters.
    unique case (mode_q)
      MODE_OFF:     led_d = 2'b00;
      MODE_STEADY:  led_d = 2'b11;
      MODE_BLINK:   led_d = phase_q ? 2'b10 : 2'b01;
      MODE_BREATHE: led_d = {2{pwm_cnt_q < duty_q}};
      default:      led_d = 2'b00;
    endcase
    active_d = (mode_q != MODE_OFF);

    // A mode change leaves all counters at their cleared defaults, which takes
    // priority over any terminal-count action that would otherwise happen.
    if (!mode_change) begin
      unique case (mode_q)
        MODE_BLINK: begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
          end
        end
        MODE_BREATHE: begin
          pwm_cnt_d = pwm_cnt_q + 1'b1;  // free-running, wraps at 2^PWM_BITS
          duty_d    = duty_q;
          dir_d     = dir_q;
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            // Step tick: bounce at the ends instead of wrapping, so the ramp
            // turns at MAX and 0 without ever repeating the end value.
            if (dir_q == DIR_UP) begin
              if (duty_q == DUTY_MAX) begin
                dir_d  = DIR_DOWN;
                duty_d = DUTY_MAX - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                dir_d  = DIR_UP;
                duty_d = DUTY_ONE;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
        default: ;  // OFF / STEADY: counters stay at their zero defaults
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      duty_q      <= '0;
      dir_q       <= DIR_UP;
      led_q       <= 2'b00;
      active_q    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
      active_q    <= active_d;
    end
  end

  assign led            = led_q;
  assign pattern_active = active_q;

endmodule

// File: tb/tb_pio_led_pattern_driver.sv
// -----------------------------------------------------------------------------
// Testbench for pio_led_pattern_driver (BLINK_HALF=4, PWM_BITS=3, STEP_DIV=2).
// A driver applies one mode/reset value per clock and pushes the expected
// {pattern_active, led} for the edge into a queue; a monitor pops and compares
// on every falling edge. The reference model tracks only the registered mode
// and the number of cycles spent in it, and derives each pattern from that
// elapsed time with plain arithmetic (blink phase, triangle-wave duty).
// -----------------------------------------------------------------------------
module tb_pio_led_pattern_driver;

  localparam int BH   = 4;
  localparam int PB   = 3;
  localparam int SD   = 2;
  localparam int DMAX = (1 << PB) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] led;
  logic       pattern_active;

  pio_led_pattern_driver #(
    .BLINK_HALF (BH),
    .PWM_BITS   (PB),
    .STEP_DIV   (SD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .led            (led),
    .pattern_active (pattern_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] exp;   // {pattern_active, led}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: registered mode and cycles elapsed since it was entered.
  int m_mode = 0;
  int m_t    = 0;

  task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got active/led=%b/%b expected %b/%b", tag,
               act[2], act[1:0], exp[2], exp[1:0]);
    end
  endtask

  // Expected output for a given registered mode after t cycles in it.
  function automatic logic [2:0] model_out(input int mq, input int t);
    int   p;
    int   duty;
    logic on;
    case (mq)
      0: return 3'b000;
      1: return 3'b111;
      2: return ((t / BH) % 2 == 1) ? 3'b110 : 3'b101;
      default: begin
        p    = (t / SD) % (2 * DMAX);
        duty = (p <= DMAX) ? p : 2 * DMAX - p;
        on   = ((t % (DMAX + 1)) < duty);
        return {1'b1, on, on};
      end
    endcase
  endfunction

  // Apply one clock's worth of input and queue what the DUT must show after it.
  task automatic step(input logic [1:0] m, input logic r, input string tag);
    exp_t e;
    mode  = m;
    reset = r;
    @(posedge clk);
    #1;
    e.tag = tag;
    e.exp = r ? 3'b000 : model_out(m_mode, m_t);
    exp_q.push_back(e);
    if (r) begin
      m_mode = 0;
      m_t    = 0;
    end else if (int'(m) != m_mode) begin
      m_mode = int'(m);
      m_t    = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic hold(input logic [1:0] m, input int n, input string tag);
    for (int i = 0; i < n; i++) step(m, 1'b0, tag);
  endtask

  // Monitor: the DUT presents a new output every clock.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, {pattern_active, led}, e.exp);
      end
    end
  end

  initial begin
    int m;
    int len;

    // Reset held with BREATHE requested, then released.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, "reset_hold");
    hold(2'b11, 6, "reset_release");

    // OFF -> STEADY -> OFF.
    hold(2'b00, 4, "off");
    hold(2'b01, 5, "steady");
    hold(2'b00, 4, "steady_to_off");

    // BLINK: strict alternation, rewrite of the same mode, restart via STEADY.
    hold(2'b10, 14, "blink");
    hold(2'b10, 6, "blink_same_mode");
    hold(2'b01, 1, "blink_detour");
    hold(2'b10, 12, "blink_restart");

    // BREATHE: more than a full triangle period of duty.
    hold(2'b00, 2, "pre_breathe");
    hold(2'b11, 40, "breathe_ramp");

    // Leave BREATHE at duty 5, go to BLINK, come back to BREATHE.
    hold(2'b00, 2, "pre_breathe2");
    hold(2'b11, 11, "breathe_to5");
    hold(2'b10, 6, "breathe_to_blink");
    hold(2'b11, 20, "breathe_restart");

    // Reset while BLINK is in phase 1, then resume.
    hold(2'b10, 7, "blink_phase1");
    step(2'b10, 1'b1, "reset_mid_blink");
    hold(2'b10, 12, "blink_after_reset");

    // Random mode segments with occasional resets.
    for (int s = 0; s < 40; s++) begin
      m   = $urandom_range(0, 3);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++)
        step(2'(m), ($urandom_range(0, 31) == 0), "random");
    end

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
